// File: rtl/fios_result_collector.sv
// Result collector at the tail of the FIOS Montgomery PE chain.
// Takes the serial (low word, carry word) stream from the last PE, LSW first.
// Each carry is folded into the next word, and the carries are resolved one
// word at a time. The normalised product is built up in a parallel register
// and handed downstream with a valid/ready handshake.
//
// Ports:
//   clock_i         rising-edge clock
//   reset_i         asynchronous, active-high reset
//   res_valid_i     a word/carry pair is present this cycle
//   res_first_i     the pair is word 0 of a new result
//   res_word_i      low result word k
//   carry_word_i    high part of word k, weight 2^(WORD_WIDTH*(k+1))
//   result_o        normalised result; word k at [WORD_WIDTH*k +: WORD_WIDTH]
//   result_top_o    excess above result_o (last carry word + running carry)
//   result_valid_o  result_o/result_top_o hold a complete result
//   result_ready_i  downstream accepts the result
//   busy_o          collection in progress
//   protocol_err_o  sticky: a word was dropped
module fios_result_collector #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned WORD_COUNT = 4
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic                             res_valid_i,
  input  logic                             res_first_i,
  input  logic [WORD_WIDTH-1:0]            res_word_i,
  input  logic [WORD_WIDTH-1:0]            carry_word_i,
  output logic [WORD_COUNT*WORD_WIDTH-1:0] result_o,
  output logic [WORD_WIDTH+1:0]            result_top_o,
  output logic                             result_valid_o,
  input  logic                             result_ready_i,
  output logic                             busy_o,
  output logic                             protocol_err_o
);

  localparam int unsigned IW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned SW = WORD_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_count;
  logic [1:0]            r_run_carry;
  logic [WORD_WIDTH-1:0] r_prev_carry;
  logic [WORD_WIDTH-1:0] r_word [WORD_COUNT];
  logic [SW-1:0]         r_top;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_handshake;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_restart;
  logic                  w_drop;
  logic                  w_last;
  logic [IW-1:0]         w_k;
  logic [WORD_WIDTH-1:0] w_prev;
  logic [1:0]            w_run;
  logic [SW-1:0]         w_sum;

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accept/drop decision, carry folding and next state
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_restart   = 1'b0;
    w_handshake = (r_state == ST_HOLD) && result_ready_i;
    w_start     = res_valid_i && res_first_i;

    case (r_state)
      ST_IDLE: begin
        w_accept  = w_start;
        w_restart = w_start;
      end
      ST_COLLECT: begin
        // A first word mid-collection aborts the partial result.
        w_accept  = res_valid_i;
        w_restart = res_first_i;
      end
      ST_HOLD: begin
        // Only a new first word that arrives with the handshake is accepted.
        w_accept  = w_handshake && w_start;
        w_restart = w_handshake && w_start;
      end
      default: begin
        w_accept  = 1'b0;
        w_restart = 1'b0;
      end
    endcase

    w_drop = res_valid_i && !w_accept;

    // On a first word, the carries from the previous result are ignored.
    w_k    = w_restart ? '0 : r_count;
    w_prev = w_restart ? '0 : r_prev_carry;
    w_run  = w_restart ? '0 : r_run_carry;
    w_sum  = SW'(res_word_i) + SW'(w_prev) + SW'(w_run);
    w_last = w_accept && (w_k == IW'(WORD_COUNT - 1));

    if (w_accept) begin
      w_state_nxt = w_last ? ST_HOLD : ST_COLLECT;
    end else if (w_handshake) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Datapath, status and registered outputs
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_count      <= '0;
      r_run_carry  <= '0;
      r_prev_carry <= '0;
      r_top        <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < int'(WORD_COUNT); i++) begin
        r_word[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_word[w_k]  <= w_sum[WORD_WIDTH-1:0];
        r_run_carry  <= w_sum[SW-1:WORD_WIDTH];
        r_prev_carry <= carry_word_i;
        // Wraps to 0 after the last word; a new result always restarts at 0.
        r_count      <= w_k + IW'(1);
      end
      if (w_last) begin
        r_top <= SW'(carry_word_i) + SW'(w_sum[SW-1:WORD_WIDTH]);
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
      r_valid <= (w_state_nxt == ST_HOLD);
      r_busy  <= (w_state_nxt == ST_COLLECT);
    end
  end

  // Flatten the word registers onto the result bus
  for (genvar g = 0; g < int'(WORD_COUNT); g++) begin : g_result
    assign result_o[g*WORD_WIDTH +: WORD_WIDTH] = r_word[g];
  end

  assign result_top_o   = r_top;
  assign result_valid_o = r_valid;
  assign busy_o         = r_busy;
  assign protocol_err_o = r_err;

endmodule
